// File: rtl/div_clk_monitor.sv
// Checker for the even divider output: measures level lengths, counts periods,
// flags duty/stuck faults and reports lock once two good periods are seen.
module div_clk_monitor #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk_1Hz_50duty_ratio,
    input  logic               clr,
    input  logic               divided_clk_even,
    input  logic               en,
    input  logic               err_clr,
    output logic               edge_pulse,
    output logic [$clog2(N):0] high_len,
    output logic [$clog2(N):0] low_len,
    output logic [CNT_W-1:0]   period_cnt,
    output logic               locked,
    output logic               err_duty,
    output logic               err_stuck
);

    localparam int W = $clog2(N) + 1;
    localparam logic [W-1:0] HALF  = W'(N / 2);
    localparam logic [W-1:0] LIMIT = W'(N);
    localparam logic [W-1:0] SAT   = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RISE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_d_q;
    logic [W-1:0]     r_run_len;
    logic [1:0]       r_good_cnt;
    logic             r_high_ok;

    logic             w_rise;
    logic             w_fall;
    logic [W-1:0]     w_run_inc;
    logic [W-1:0]     w_run_nxt;
    logic [1:0]       w_good_nxt;
    logic             w_high_ok_nxt;
    logic             w_edge_nxt;
    logic [W-1:0]     w_high_len_nxt;
    logic [W-1:0]     w_low_len_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic             w_locked_nxt;
    logic             w_duty_set;
    logic             w_stuck_set;

    assign w_rise    = divided_clk_even & ~r_d_q;
    assign w_fall    = ~divided_clk_even & r_d_q;
    assign w_run_inc = (r_run_len == SAT) ? r_run_len : r_run_len + W'(1);

    always_ff @(posedge clk_1Hz_50duty_ratio or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_run_nxt      = r_run_len;
        w_good_nxt     = r_good_cnt;
        w_high_ok_nxt  = r_high_ok;
        w_edge_nxt     = 1'b0;
        w_high_len_nxt = high_len;
        w_low_len_nxt  = low_len;
        w_period_nxt   = period_cnt;
        w_locked_nxt   = locked;
        w_duty_set     = 1'b0;
        w_stuck_set    = 1'b0;
        if (!en) begin
            w_state_nxt   = S_IDLE;
            w_run_nxt     = '0;
            w_good_nxt    = 2'd0;
            w_high_ok_nxt = 1'b0;
            w_locked_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_RISE;
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        w_edge_nxt    = 1'b1;
                        w_run_nxt     = W'(1);
                        w_high_ok_nxt = 1'b0;
                        w_state_nxt   = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        w_edge_nxt     = 1'b1;
                        w_high_len_nxt = r_run_len;
                        w_run_nxt      = W'(1);
                        w_state_nxt    = S_LOW;
                        if (r_run_len == HALF) begin
                            w_high_ok_nxt = 1'b1;
                        end else begin
                            w_high_ok_nxt = 1'b0;
                            w_duty_set    = 1'b1;
                            w_good_nxt    = 2'd0;
                            w_locked_nxt  = 1'b0;
                        end
                    end else if (w_run_inc == LIMIT) begin
                        w_stuck_set   = 1'b1;
                        w_run_nxt     = '0;
                        w_good_nxt    = 2'd0;
                        w_high_ok_nxt = 1'b0;
                        w_locked_nxt  = 1'b0;
                        w_state_nxt   = S_WAIT_RISE;
                    end else begin
                        w_run_nxt = w_run_inc;
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        w_edge_nxt    = 1'b1;
                        w_low_len_nxt = r_run_len;
                        w_run_nxt     = W'(1);
                        w_period_nxt  = period_cnt + CNT_W'(1);
                        w_high_ok_nxt = 1'b0;
                        w_state_nxt   = S_HIGH;
                        if (r_run_len != HALF) begin
                            w_duty_set   = 1'b1;
                            w_good_nxt   = 2'd0;
                            w_locked_nxt = 1'b0;
                        end else if (r_high_ok) begin
                            // second consecutive good period locks
                            if (r_good_cnt != 2'd2) begin
                                w_good_nxt = r_good_cnt + 2'd1;
                            end
                            if (r_good_cnt != 2'd0) begin
                                w_locked_nxt = 1'b1;
                            end
                        end
                    end else if (w_run_inc == LIMIT) begin
                        w_stuck_set   = 1'b1;
                        w_run_nxt     = '0;
                        w_good_nxt    = 2'd0;
                        w_high_ok_nxt = 1'b0;
                        w_locked_nxt  = 1'b0;
                        w_state_nxt   = S_WAIT_RISE;
                    end else begin
                        w_run_nxt = w_run_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1Hz_50duty_ratio or negedge clr) begin
        if (!clr) begin
            r_d_q      <= 1'b0;
            r_run_len  <= '0;
            r_good_cnt <= 2'd0;
            r_high_ok  <= 1'b0;
            edge_pulse <= 1'b0;
            high_len   <= '0;
            low_len    <= '0;
            period_cnt <= '0;
            locked     <= 1'b0;
            err_duty   <= 1'b0;
            err_stuck  <= 1'b0;
        end else begin
            r_d_q      <= divided_clk_even;
            r_run_len  <= w_run_nxt;
            r_good_cnt <= w_good_nxt;
            r_high_ok  <= w_high_ok_nxt;
            edge_pulse <= w_edge_nxt;
            high_len   <= w_high_len_nxt;
            low_len    <= w_low_len_nxt;
            period_cnt <= w_period_nxt;
            locked     <= w_locked_nxt;
            // a fault on the clearing tick must not be lost
            err_duty   <= w_duty_set | (err_duty & ~err_clr);
            err_stuck  <= w_stuck_set | (err_stuck & ~err_clr);
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: scoreboarded edge snapshots plus scenario checks,
// with a CNT_W=4 twin instance sharing the stimulus for wrap coverage.
module tb_div_clk_monitor;

    typedef enum {M_IDLE, M_WAIT, M_MEAS} mode_t;

    typedef struct packed {
        logic [3:0] hl;
        logic [3:0] ll;
        logic [7:0] pc;
        logic       lk;
        logic       ed;
    } exp_t;

    logic       clk;
    logic       clr;
    logic       d;
    logic       en;
    logic       err_clr;
    logic       ep;
    logic [3:0] hl;
    logic [3:0] ll;
    logic [7:0] pc;
    logic       lk;
    logic       ed;
    logic       es;
    logic       ep4;
    logic [3:0] hl4;
    logic [3:0] ll4;
    logic [3:0] pc4;
    logic       lk4;
    logic       ed4;
    logic       es4;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t  sb_q[$];
    exp_t  sb_e;

    mode_t      mode = M_IDLE;
    logic       m_d = 1'b0;
    int         m_run = 0;
    logic [3:0] m_hl = '0;
    logic [3:0] m_ll = '0;
    logic [7:0] m_pc = '0;
    logic       m_lk = 1'b0;
    int         m_good = 0;
    logic       m_hok = 1'b0;
    logic       m_ed = 1'b0;
    logic       m_es = 1'b0;

    div_clk_monitor #(.N(8), .CNT_W(8)) u_dut (
        .clk_1Hz_50duty_ratio(clk),
        .clr(clr),
        .divided_clk_even(d),
        .en(en),
        .err_clr(err_clr),
        .edge_pulse(ep),
        .high_len(hl),
        .low_len(ll),
        .period_cnt(pc),
        .locked(lk),
        .err_duty(ed),
        .err_stuck(es)
    );

    div_clk_monitor #(.N(8), .CNT_W(4)) u_dut4 (
        .clk_1Hz_50duty_ratio(clk),
        .clr(clr),
        .divided_clk_even(d),
        .en(en),
        .err_clr(err_clr),
        .edge_pulse(ep4),
        .high_len(hl4),
        .low_len(ll4),
        .period_cnt(pc4),
        .locked(lk4),
        .err_duty(ed4),
        .err_stuck(es4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // every reported edge must match the next queued snapshot on both DUTs
    always @(negedge clk) begin
        if (ep || ep4) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_edge: ep=%b ep4=%b with nothing expected", ep, ep4);
            end else begin
                sb_e = sb_q.pop_front();
                if ({ep, hl, ll, pc, lk, ed} !== {1'b1, sb_e} ||
                    {ep4, hl4, ll4, pc4, lk4, ed4} !==
                    {1'b1, sb_e.hl, sb_e.ll, sb_e.pc[3:0], sb_e.lk, sb_e.ed}) begin
                    n_fail++;
                    $display("FAIL sb_edge @%0t: got hl=%0d ll=%0d pc=%0d lk=%b ed=%b pc4=%0d ep4=%b, want hl=%0d ll=%0d pc=%0d lk=%b ed=%b",
                             $time, hl, ll, pc, lk, ed, pc4, ep4,
                             sb_e.hl, sb_e.ll, sb_e.pc, sb_e.lk, sb_e.ed);
                end
            end
        end
    end

    // drive level v for n ticks; model the edge (if any) and queue its snapshot
    task automatic seg(input logic v, input int n, input logic ec);
        logic set;
        logic push;
        set  = 1'b0;
        push = 1'b0;
        if (v !== m_d && mode != M_IDLE) begin
            if (v) begin
                if (mode == M_WAIT) begin
                    mode = M_MEAS;
                    push = 1'b1;
                end else begin
                    m_ll = 4'(m_run);
                    m_pc = m_pc + 8'd1;
                    push = 1'b1;
                    if (m_run != 4) begin
                        set    = 1'b1;
                        m_good = 0;
                        m_lk   = 1'b0;
                    end else if (m_hok) begin
                        if (m_good < 2) m_good++;
                        if (m_good == 2) m_lk = 1'b1;
                    end
                    m_hok = 1'b0;
                end
            end else if (mode == M_MEAS) begin
                m_hl = 4'(m_run);
                push = 1'b1;
                if (m_run == 4) begin
                    m_hok = 1'b1;
                end else begin
                    m_hok  = 1'b0;
                    set    = 1'b1;
                    m_good = 0;
                    m_lk   = 1'b0;
                end
            end
        end
        if (set) m_ed = 1'b1;
        else if (ec) m_ed = 1'b0;
        if (ec) m_es = 1'b0;
        if (push) sb_q.push_back('{m_hl, m_ll, m_pc, m_lk, m_ed});
        m_run = (v === m_d) ? m_run + n : n;
        m_d   = v;
        d       = v;
        err_clr = ec;
        @(posedge clk);
        #2;
        err_clr = 1'b0;
        repeat (n - 1) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        d = 1'b0;
        en = 1'b0;
        err_clr = 1'b0;
        #12;
        n_tests++;
        if ({ep, hl, ll, pc, lk, ed, es} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", {ep, hl, ll, pc, lk, ed, es});
        end
        n_tests++;
        if ({ep4, hl4, ll4, pc4, lk4, ed4, es4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs4: got %h, want 0", {ep4, hl4, ll4, pc4, lk4, ed4, es4});
        end
        @(posedge clk);
        #2;
        clr = 1'b1;
        en = 1'b1;
        seg(1'b0, 2, 1'b0);
        mode = M_WAIT;
    endtask

    task automatic test_lock();
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        n_tests++;
        if ({lk, hl, ll, pc, ed, es} !== {1'b1, 4'd4, 4'd4, 8'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL lock_two_periods: got lk=%b hl=%0d ll=%0d pc=%0d ed=%b es=%b, want 1 4 4 2 0 0",
                     lk, hl, ll, pc, ed, es);
        end
    endtask

    task automatic test_duty();
        seg(1'b1, 5, 1'b0);
        seg(1'b0, 4, 1'b0);
        n_tests++;
        if ({hl, ed, lk} !== {4'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL duty_stretch: got hl=%0d ed=%b lk=%b, want 5 1 0", hl, ed, lk);
        end
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        n_tests++;
        if ({lk, ed} !== 2'b11) begin
            n_fail++;
            $display("FAIL duty_relock_sticky: got lk=%b ed=%b, want 1 1", lk, ed);
        end
        seg(1'b1, 4, 1'b1);
        n_tests++;
        if (ed !== 1'b0) begin
            n_fail++;
            $display("FAIL duty_err_clr: got ed=%b, want 0", ed);
        end
        seg(1'b0, 4, 1'b0);
    endtask

    task automatic test_stuck();
        seg(1'b1, 1, 1'b0);
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk);
            #2;
            if (k == 7) begin
                n_tests++;
                if ({es, lk} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL stuck_tick7: got es=%b lk=%b, want 0 1", es, lk);
                end
            end
            if (k == 8) begin
                n_tests++;
                if ({es, lk, es4, lk4} !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL stuck_tick8: got es=%b lk=%b es4=%b lk4=%b, want 1 0 1 0",
                             es, lk, es4, lk4);
                end
            end
        end
        mode   = M_WAIT;
        m_lk   = 1'b0;
        m_good = 0;
        m_hok  = 1'b0;
        m_es   = 1'b1;
        m_run  = 8;
        seg(1'b1, 2, 1'b0);
        seg(1'b0, 1, 1'b0);
        n_tests++;
        if (ep !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_fall_ignored: got ep=%b, want 0", ep);
        end
        seg(1'b0, 2, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b1);
        n_tests++;
        if (es !== m_es) begin
            n_fail++;
            $display("FAIL stuck_err_clr: got es=%b, want %b", es, m_es);
        end
        seg(1'b0, 4, 1'b0);
    endtask

    task automatic test_wrap();
        int seen;
        seen = 0;
        for (int i = 0; i < 18; i++) begin
            seg(1'b1, 4, 1'b0);
            if (m_pc[3:0] == 4'd0) begin
                seen++;
                n_tests++;
                if ({pc4, lk4, ed4, es4, hl4, ll4} !== {4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd4} ||
                    pc !== m_pc) begin
                    n_fail++;
                    $display("FAIL wrap_15_to_0: got pc4=%0d lk4=%b ed4=%b es4=%b pc=%0d, want 0 1 0 0 %0d",
                             pc4, lk4, ed4, es4, pc, m_pc);
                end
            end
            seg(1'b0, 4, 1'b0);
        end
        n_tests++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL wrap_seen: got %0d wraps, want 1", seen);
        end
    endtask

    task automatic test_clr();
        seg(1'b1, 2, 1'b0);
        #1;
        clr = 1'b0;
        #1;
        n_tests++;
        if ({ep, hl, ll, pc, lk, ed, es, ep4, hl4, ll4, pc4, lk4, ed4, es4} !== '0) begin
            n_fail++;
            $display("FAIL clr_async: got %h / %h, want 0",
                     {ep, hl, ll, pc, lk, ed, es}, {ep4, hl4, ll4, pc4, lk4, ed4, es4});
        end
        @(posedge clk);
        #2;
        n_tests++;
        if ({ep, hl, ll, pc, lk, ed, es} !== '0) begin
            n_fail++;
            $display("FAIL clr_held: got %h, want 0", {ep, hl, ll, pc, lk, ed, es});
        end
        clr    = 1'b1;
        mode   = M_IDLE;
        m_hl   = '0;
        m_ll   = '0;
        m_pc   = '0;
        m_lk   = 1'b0;
        m_good = 0;
        m_hok  = 1'b0;
        m_ed   = 1'b0;
        m_es   = 1'b0;
        seg(1'b0, 2, 1'b0);
        mode = M_WAIT;
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 3, 1'b0);
        seg(1'b0, 4, 1'b1);
        n_tests++;
        if ({ed, ed4, hl} !== {1'b1, 1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL clr_set_wins: got ed=%b ed4=%b hl=%0d, want 1 1 3", ed, ed4, hl);
        end
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 2, 1'b0);
    endtask

    task automatic test_en_drop();
        n_tests++;
        if (lk !== 1'b1) begin
            n_fail++;
            $display("FAIL en_prelock: got lk=%b, want 1", lk);
        end
        en     = 1'b0;
        mode   = M_IDLE;
        m_lk   = 1'b0;
        m_good = 0;
        m_hok  = 1'b0;
        seg(1'b0, 1, 1'b0);
        n_tests++;
        if ({lk, hl, ll, pc, ed} !== {1'b0, m_hl, m_ll, m_pc, m_ed}) begin
            n_fail++;
            $display("FAIL en_drop_hold: got lk=%b hl=%0d ll=%0d pc=%0d ed=%b, want 0 %0d %0d %0d %b",
                     lk, hl, ll, pc, ed, m_hl, m_ll, m_pc, m_ed);
        end
        seg(1'b1, 3, 1'b0);
        en   = 1'b1;
        mode = M_WAIT;
        seg(1'b1, 2, 1'b0);
        seg(1'b0, 1, 1'b0);
        n_tests++;
        if (ep !== 1'b0) begin
            n_fail++;
            $display("FAIL en_fall_ignored: got ep=%b, want 0", ep);
        end
        seg(1'b0, 3, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 4, 1'b0);
        seg(1'b1, 4, 1'b0);
        seg(1'b0, 2, 1'b0);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected edges never seen, want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_duty();
        test_stuck();
        test_wrap();
        test_clr();
        test_en_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
